// File: rtl/button_conditioner.sv
// Pushbutton front-end: two-flop synchronisers, per-button debounce FSMs, and
// registered Enable/UpDown toggles plus one-cycle press pulses.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic Clk_In,
  input  logic Rst,
  input  logic Btn_Enable,
  input  logic Btn_Dir,
  input  logic Btn_Clear,
  output logic Enable,
  output logic UpDown,
  output logic Cnt_Rst,
  output logic Enable_Pulse,
  output logic Dir_Pulse
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

  // channel index: 0 = enable, 1 = direction, 2 = clear
  logic [2:0]       raw_s;
  logic [2:0]       sync1_r;
  logic [2:0]       sync2_r;
  state_t           state_r     [3];
  state_t           state_nxt_s [3];
  logic [CNT_W-1:0] cnt_r       [3];
  logic [CNT_W-1:0] cnt_nxt_s   [3];
  logic [2:0]       accept_s;

  logic enable_r;
  logic updown_r;
  logic cnt_rst_r;
  logic enable_pulse_r;
  logic dir_pulse_r;

  assign raw_s = {Btn_Clear, Btn_Dir, Btn_Enable};

  // Two-flop synchroniser for the raw asynchronous buttons
  always_ff @(posedge Clk_In) begin
    if (Rst) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Debounce FSM and counter registers for all three channels
  always_ff @(posedge Clk_In) begin
    for (int i = 0; i < 3; i++) begin
      if (Rst) begin
        state_r[i] <= IDLE_LOW;
        cnt_r[i]   <= CNT_ZERO;
      end else begin
        state_r[i] <= state_nxt_s[i];
        cnt_r[i]   <= cnt_nxt_s[i];
      end
    end
  end

  // Next-state logic; a press is accepted only on the WAIT_HIGH -> IDLE_HIGH step
  always_comb begin
    accept_s = 3'b000;
    for (int i = 0; i < 3; i++) begin
      state_nxt_s[i] = state_r[i];
      cnt_nxt_s[i]   = cnt_r[i];
      case (state_r[i])
        IDLE_LOW: begin
          if (sync2_r[i]) begin
            state_nxt_s[i] = WAIT_HIGH;
            cnt_nxt_s[i]   = CNT_ONE;
          end else begin
            cnt_nxt_s[i]   = CNT_ZERO;
          end
        end
        WAIT_HIGH: begin
          if (!sync2_r[i]) begin
            state_nxt_s[i] = IDLE_LOW;
            cnt_nxt_s[i]   = CNT_ZERO;
          end else if (cnt_r[i] == CNT_MAX) begin
            state_nxt_s[i] = IDLE_HIGH;
            cnt_nxt_s[i]   = CNT_ZERO;
            accept_s[i]    = 1'b1;
          end else begin
            cnt_nxt_s[i]   = cnt_r[i] + CNT_ONE;
          end
        end
        IDLE_HIGH: begin
          if (!sync2_r[i]) begin
            state_nxt_s[i] = WAIT_LOW;
            cnt_nxt_s[i]   = CNT_ONE;
          end else begin
            cnt_nxt_s[i]   = CNT_ZERO;
          end
        end
        WAIT_LOW: begin
          if (sync2_r[i]) begin
            state_nxt_s[i] = IDLE_HIGH;
            cnt_nxt_s[i]   = CNT_ZERO;
          end else if (cnt_r[i] == CNT_MAX) begin
            state_nxt_s[i] = IDLE_LOW;
            cnt_nxt_s[i]   = CNT_ZERO;
          end else begin
            cnt_nxt_s[i]   = cnt_r[i] + CNT_ONE;
          end
        end
        default: begin
          state_nxt_s[i] = IDLE_LOW;
          cnt_nxt_s[i]   = CNT_ZERO;
        end
      endcase
    end
  end

  // Registered levels and pulses driven from accepted presses
  always_ff @(posedge Clk_In) begin
    if (Rst) begin
      enable_r       <= 1'b0;
      updown_r       <= 1'b1;
      cnt_rst_r      <= 1'b0;
      enable_pulse_r <= 1'b0;
      dir_pulse_r    <= 1'b0;
    end else begin
      enable_r       <= enable_r ^ accept_s[0];
      updown_r       <= updown_r ^ accept_s[1];
      cnt_rst_r      <= accept_s[2];
      enable_pulse_r <= accept_s[0];
      dir_pulse_r    <= accept_s[1];
    end
  end

  assign Enable       = enable_r;
  assign UpDown       = updown_r;
  assign Cnt_Rst      = cnt_rst_r;
  assign Enable_Pulse = enable_pulse_r;
  assign Dir_Pulse    = dir_pulse_r;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner with a 4-cycle debounce,
// so a press sampled at edge n shows its pulse right after edge n+6.
module tb_button_conditioner;

  logic clk;
  logic rst;
  logic btn_enable;
  logic btn_dir;
  logic btn_clear;
  logic enable;
  logic updown;
  logic cnt_rst;
  logic enable_pulse;
  logic dir_pulse;

  int pass_cnt;
  int total_cnt;
  int dir_pulses;

  button_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .Clk_In      (clk),
    .Rst         (rst),
    .Btn_Enable  (btn_enable),
    .Btn_Dir     (btn_dir),
    .Btn_Clear   (btn_clear),
    .Enable      (enable),
    .UpDown      (updown),
    .Cnt_Rst     (cnt_rst),
    .Enable_Pulse(enable_pulse),
    .Dir_Pulse   (dir_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one active edge, then settle so outputs are sampled away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
  endtask

  initial begin
    pass_cnt   = 0;
    total_cnt  = 0;
    dir_pulses = 0;
    rst        = 1'b1;
    btn_enable = 1'b0;
    btn_dir    = 1'b0;
    btn_clear  = 1'b0;

    // reset state
    tick();
    tick();
    check("rst_enable", enable, 1'b0);
    check("rst_updown", updown, 1'b1);
    check("rst_cnt_rst", cnt_rst, 1'b0);
    check("rst_en_pulse", enable_pulse, 1'b0);
    check("rst_dir_pulse", dir_pulse, 1'b0);
    rst = 1'b0;

    // clean press held 20 cycles: single pulse after edge n+6, Enable 0->1
    btn_enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("press_en_pulse", enable_pulse, (k == 6) ? 1'b1 : 1'b0);
      check("press_enable", enable, (k >= 6) ? 1'b1 : 1'b0);
      check("press_cnt_rst", cnt_rst, 1'b0);
    end
    btn_enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("release_en_pulse", enable_pulse, 1'b0);
      check("release_enable", enable, 1'b1);
    end

    // bounce 1,1,0,1,1,1,0 never reaches the debounce threshold
    for (int k = 0; k < 17; k++) begin
      case (k)
        0, 1, 3, 4, 5: btn_dir = 1'b1;
        default:       btn_dir = 1'b0;
      endcase
      tick();
      check("bounce_dir_pulse", dir_pulse, 1'b0);
      check("bounce_updown", updown, 1'b1);
    end

    // three press/release cycles: UpDown 1->0->1->0
    for (int p = 0; p < 3; p++) begin
      logic before_v;
      before_v = (p == 1) ? 1'b0 : 1'b1;
      btn_dir = 1'b1;
      for (int k = 0; k < 10; k++) begin
        tick();
        if (dir_pulse === 1'b1) dir_pulses++;
        check("toggle_dir_pulse", dir_pulse, (k == 6) ? 1'b1 : 1'b0);
        check("toggle_updown", updown, (k >= 6) ? ~before_v : before_v);
      end
      btn_dir = 1'b0;
      for (int k = 0; k < 10; k++) begin
        tick();
        if (dir_pulse === 1'b1) dir_pulses++;
        check("toggle_rel_pulse", dir_pulse, 1'b0);
        check("toggle_rel_updown", updown, ~before_v);
      end
    end
    total_cnt++;
    assert (dir_pulses == 3) pass_cnt++;
    else $error("FAIL dir_pulse_count: observed %0d expected 3", dir_pulses);

    // clear press held 15 cycles: one Cnt_Rst cycle, levels untouched
    btn_clear = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      check("clear_cnt_rst", cnt_rst, (k == 6) ? 1'b1 : 1'b0);
      check("clear_enable", enable, 1'b1);
      check("clear_updown", updown, 1'b0);
    end
    btn_clear = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("clear_rel_cnt_rst", cnt_rst, 1'b0);
    end

    // simultaneous enable + clear: both pulses in the same cycle, Enable 1->0
    btn_enable = 1'b1;
    btn_clear  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("sim_en_pulse", enable_pulse, (k == 6) ? 1'b1 : 1'b0);
      check("sim_cnt_rst", cnt_rst, (k == 6) ? 1'b1 : 1'b0);
      check("sim_enable", enable, (k >= 6) ? 1'b0 : 1'b1);
      check("sim_dir_pulse", dir_pulse, 1'b0);
    end
    btn_enable = 1'b0;
    btn_clear  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("sim_rel_en_pulse", enable_pulse, 1'b0);
    end

    // reset at edge n+4 mid-debounce; fresh press accepted at edge n+11
    btn_enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("mid_pre_en_pulse", enable_pulse, 1'b0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_enable", enable, 1'b0);
    check("mid_rst_updown", updown, 1'b1);
    check("mid_rst_en_pulse", enable_pulse, 1'b0);
    for (int e = 5; e < 16; e++) begin
      tick();
      check("mid_en_pulse", enable_pulse, (e == 11) ? 1'b1 : 1'b0);
      check("mid_enable", enable, (e >= 11) ? 1'b1 : 1'b0);
    end
    btn_enable = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
